// File: rtl/trap_sequencer.sv
// Trap-entry / trap-return sequencer: captures a trap or mret, streams the
// machine-mode CSR updates through the secondary CSR port, then redirects the PC.
module trap_sequencer #(
  parameter logic [31:0] RESET_PC          = 32'h0000_0000,
  parameter int          CSR_ADDRESS_WIDTH = 12
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         exc_valid_i,
  input  logic [30:0]                  exc_cause_i,
  input  logic [31:0]                  exc_pc_i,
  input  logic [31:0]                  exc_tval_i,
  input  logic                         mret_i,
  input  logic [31:0]                  int_pc_i,
  input  logic                         timer_irq_i,
  input  logic                         ext_irq_i,
  input  logic                         ex_csr_we_i,
  input  logic [31:0]                  csr_mtvec_i,
  input  logic [31:0]                  csr_mepc_i,
  input  logic [31:0]                  csr_mstatus_i,
  input  logic                         global_interrupt_enable_i,
  output logic                         csr_we_clint,
  output logic [CSR_ADDRESS_WIDTH-1:0] csr_waddr_clint,
  output logic [31:0]                  csr_wdata_clint,
  output logic                         hold_o,
  output logic                         flush_o,
  output logic                         jump_o,
  output logic [31:0]                  jump_addr_o,
  output logic                         busy_o,
  output logic [2:0]                   state_dbg
);

  typedef enum logic [2:0] {
    IDLE, W_MEPC, W_MCAUSE, W_MTVAL, W_MSTATUS, R_MSTATUS, JUMP
  } state_t;

  localparam logic [CSR_ADDRESS_WIDTH-1:0] ADDR_MSTATUS = CSR_ADDRESS_WIDTH'(12'h300);
  localparam logic [CSR_ADDRESS_WIDTH-1:0] ADDR_MEPC    = CSR_ADDRESS_WIDTH'(12'h341);
  localparam logic [CSR_ADDRESS_WIDTH-1:0] ADDR_MCAUSE  = CSR_ADDRESS_WIDTH'(12'h342);
  localparam logic [CSR_ADDRESS_WIDTH-1:0] ADDR_MTVAL   = CSR_ADDRESS_WIDTH'(12'h343);

  state_t      state, state_nxt;
  logic [31:0] mepc_q, mcause_q, mtval_q, jump_addr_q;
  logic        mret_q;

  logic take_exc, take_ext, take_tmr, take_mret, take_trap, accept;
  logic [31:0] base, jump_target, mstatus_trap, mstatus_mret;

  // Fixed priority: exception, external, timer, mret.
  assign take_exc  = exc_valid_i;
  assign take_ext  = !take_exc && global_interrupt_enable_i && ext_irq_i;
  assign take_tmr  = !take_exc && global_interrupt_enable_i && !ext_irq_i && timer_irq_i;
  assign take_trap = take_exc || take_ext || take_tmr;
  assign take_mret = !take_trap && mret_i;
  assign accept    = (state == IDLE) && (take_trap || take_mret);

  assign base = {csr_mtvec_i[31:2], 2'b00};
  // Vectored mode only applies to interrupts; mcause[31] marks an interrupt.
  assign jump_target = mret_q ? csr_mepc_i :
                       (mcause_q[31] && csr_mtvec_i[1:0] == 2'b01) ?
                       base + {mcause_q[29:0], 2'b00} : base;

  assign mstatus_trap = {csr_mstatus_i[31:13], 2'b11, csr_mstatus_i[10:8],
                         csr_mstatus_i[3], csr_mstatus_i[6:4], 1'b0, csr_mstatus_i[2:0]};
  assign mstatus_mret = {csr_mstatus_i[31:13], 2'b11, csr_mstatus_i[10:8],
                         1'b1, csr_mstatus_i[6:4], csr_mstatus_i[7], csr_mstatus_i[2:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mepc_q      <= '0;
      mcause_q    <= '0;
      mtval_q     <= '0;
      mret_q      <= 1'b0;
      jump_addr_q <= RESET_PC;
    end else begin
      if (accept) begin
        mret_q <= take_mret;
        if (take_exc) begin
          mcause_q <= {1'b0, exc_cause_i};
          mepc_q   <= exc_pc_i;
          mtval_q  <= exc_tval_i;
        end else if (take_ext || take_tmr) begin
          mcause_q <= take_ext ? 32'h8000_000B : 32'h8000_0007;
          mepc_q   <= int_pc_i;
          mtval_q  <= '0;
        end
      end
      if (state == JUMP) jump_addr_q <= jump_target;
    end
  end

  // A write state only advances once the CSR port was actually ours.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (take_trap) state_nxt = W_MEPC;
                 else if (take_mret) state_nxt = R_MSTATUS;
      W_MEPC:    if (!ex_csr_we_i) state_nxt = W_MCAUSE;
      W_MCAUSE:  if (!ex_csr_we_i) state_nxt = W_MTVAL;
      W_MTVAL:   if (!ex_csr_we_i) state_nxt = W_MSTATUS;
      W_MSTATUS: if (!ex_csr_we_i) state_nxt = JUMP;
      R_MSTATUS: if (!ex_csr_we_i) state_nxt = JUMP;
      JUMP:      state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_comb begin
    csr_we_clint    = 1'b0;
    csr_waddr_clint = '0;
    csr_wdata_clint = '0;
    hold_o          = 1'b1;
    flush_o         = 1'b0;
    jump_o          = 1'b0;
    jump_addr_o     = jump_addr_q;
    busy_o          = (state != IDLE);
    case (state)
      IDLE:      hold_o = accept;
      W_MEPC:    begin csr_waddr_clint = ADDR_MEPC;    csr_wdata_clint = mepc_q;       end
      W_MCAUSE:  begin csr_waddr_clint = ADDR_MCAUSE;  csr_wdata_clint = mcause_q;     end
      W_MTVAL:   begin csr_waddr_clint = ADDR_MTVAL;   csr_wdata_clint = mtval_q;      end
      W_MSTATUS: begin csr_waddr_clint = ADDR_MSTATUS; csr_wdata_clint = mstatus_trap; end
      R_MSTATUS: begin csr_waddr_clint = ADDR_MSTATUS; csr_wdata_clint = mstatus_mret; end
      JUMP: begin
        flush_o     = 1'b1;
        jump_o      = 1'b1;
        jump_addr_o = jump_target;
      end
      default: hold_o = 1'b0;
    endcase
    if (state != IDLE && state != JUMP) csr_we_clint = !ex_csr_we_i;
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_trap_sequencer.sv
// Bench for trap_sequencer: directed scenarios plus random traffic, each
// transaction predicted as an ordered list of CSR writes and a redirect target.
module tb_trap_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        exc_valid_i, mret_i, timer_irq_i, ext_irq_i, ex_csr_we_i;
  logic [30:0] exc_cause_i;
  logic [31:0] exc_pc_i, exc_tval_i, int_pc_i;
  logic [31:0] csr_mtvec_i, csr_mepc_i, csr_mstatus_i;
  logic        global_interrupt_enable_i;
  logic        csr_we_clint, hold_o, flush_o, jump_o, busy_o;
  logic [11:0] csr_waddr_clint;
  logic [31:0] csr_wdata_clint, jump_addr_o;
  logic [2:0]  state_dbg;

  int n_checks = 0;
  int n_fail   = 0;
  logic [43:0] exp_q[$];

  trap_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .exc_valid_i(exc_valid_i), .exc_cause_i(exc_cause_i), .exc_pc_i(exc_pc_i),
    .exc_tval_i(exc_tval_i), .mret_i(mret_i), .int_pc_i(int_pc_i),
    .timer_irq_i(timer_irq_i), .ext_irq_i(ext_irq_i), .ex_csr_we_i(ex_csr_we_i),
    .csr_mtvec_i(csr_mtvec_i), .csr_mepc_i(csr_mepc_i), .csr_mstatus_i(csr_mstatus_i),
    .global_interrupt_enable_i(global_interrupt_enable_i),
    .csr_we_clint(csr_we_clint), .csr_waddr_clint(csr_waddr_clint),
    .csr_wdata_clint(csr_wdata_clint), .hold_o(hold_o), .flush_o(flush_o),
    .jump_o(jump_o), .jump_addr_o(jump_addr_o), .busy_o(busy_o), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [43:0] got, input logic [43:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    exc_valid_i = 0; mret_i = 0; timer_irq_i = 0; ext_irq_i = 0; ex_csr_we_i = 0;
    exc_cause_i = '0; exc_pc_i = '0; exc_tval_i = '0; int_pc_i = '0;
  endtask

  // One request presented in an IDLE cycle, followed to its redirect.
  task automatic do_txn(input logic exc_v, input logic ext, input logic tmr, input logic mr,
                        input logic mie, input logic [30:0] cause, input logic [31:0] pc,
                        input logic [31:0] tval, input logic [31:0] ipc,
                        input logic [31:0] mtvec, input logic [31:0] mepc,
                        input logic [31:0] mstatus, input int coll_pct,
                        input logic [15:0] coll_pat, input logic keep_irq);
    int kind, i;
    logic coll;
    logic [31:0] cause_w, exp_pc, exp_tval, exp_jump, ms_trap, ms_mret, base;
    logic [43:0] head;
    kind = exc_v ? 0 : (mie && ext) ? 1 : (mie && tmr) ? 2 : mr ? 3 : 4;
    cause_w = 0; exp_pc = 0; exp_tval = 0;
    case (kind)
      0: begin cause_w = {1'b0, cause}; exp_pc = pc;  exp_tval = tval; end
      1: begin cause_w = 32'h8000_000B; exp_pc = ipc; exp_tval = 0;    end
      2: begin cause_w = 32'h8000_0007; exp_pc = ipc; exp_tval = 0;    end
      default: ;
    endcase
    ms_trap = (mstatus & ~32'h1888) | (mstatus[3] ? 32'h80 : 32'h0) | 32'h1800;
    ms_mret = (mstatus & ~32'h1888) | (mstatus[7] ? 32'h8 : 32'h0) | 32'h80 | 32'h1800;
    base = mtvec & 32'hFFFF_FFFC;
    exp_q.delete();
    if (kind < 3) begin
      exp_q.push_back({12'h341, exp_pc});
      exp_q.push_back({12'h342, cause_w});
      exp_q.push_back({12'h343, exp_tval});
      exp_q.push_back({12'h300, ms_trap});
      exp_jump = (kind != 0 && mtvec[1:0] == 2'b01) ? base + (cause_w & 32'h7FFF_FFFF) * 4 : base;
    end else begin
      exp_q.push_back({12'h300, ms_mret});
      exp_jump = mepc;
    end

    exc_valid_i = exc_v; ext_irq_i = ext; timer_irq_i = tmr; mret_i = mr;
    global_interrupt_enable_i = mie; exc_cause_i = cause; exc_pc_i = pc;
    exc_tval_i = tval; int_pc_i = ipc; csr_mtvec_i = mtvec; csr_mepc_i = mepc;
    csr_mstatus_i = mstatus; ex_csr_we_i = 0;
    #1;
    check("idle_busy", 44'(busy_o), 44'(0));
    check("accept_hold", 44'(hold_o), 44'(kind != 4));
    check("idle_we", 44'(csr_we_clint), 44'(0));
    step();
    exc_valid_i = 0; mret_i = 0;
    if (!keep_irq) begin ext_irq_i = 0; timer_irq_i = 0; end
    if (kind == 4) begin
      #1;
      check("ignored_busy", 44'(busy_o), 44'(0));
      check("ignored_hold", 44'(hold_o), 44'(0));
      return;
    end

    i = 0;
    while (exp_q.size() > 0 && i < 64) begin
      coll = (i < 16 && coll_pat[i]) || ($urandom_range(0, 99) < coll_pct);
      ex_csr_we_i = coll;
      #1;
      head = exp_q[0];
      check("seq_hold", 44'(hold_o), 44'(1));
      check("seq_jump", 44'(jump_o), 44'(0));
      check("csr_we", 44'(csr_we_clint), 44'(!coll));
      check("csr_addr", 44'(csr_waddr_clint), 44'(head[43:32]));
      check("csr_data", 44'(csr_wdata_clint), 44'(head[31:0]));
      if (!coll) void'(exp_q.pop_front());
      step();
      i++;
    end
    check("writes_done", 44'(exp_q.size()), 44'(0));

    ex_csr_we_i = 1'($urandom_range(0, 1));
    #1;
    check("jump", 44'(jump_o), 44'(1));
    check("flush", 44'(flush_o), 44'(1));
    check("jump_hold", 44'(hold_o), 44'(1));
    check("jump_we", 44'(csr_we_clint), 44'(0));
    check("jump_addr", 44'(jump_addr_o), 44'(exp_jump));
    step();
    ex_csr_we_i = 0;
    #1;
    check("post_jump", 44'(jump_o), 44'(0));
    check("post_flush", 44'(flush_o), 44'(0));
    check("post_busy", 44'(busy_o), 44'(0));
    check("addr_held", 44'(jump_addr_o), 44'(exp_jump));
    check("post_hold", 44'(hold_o), 44'(mie && (ext_irq_i || timer_irq_i)));
  endtask

  initial begin
    rst_n = 0;
    clear_inputs();
    global_interrupt_enable_i = 0;
    csr_mtvec_i = 0; csr_mepc_i = 0; csr_mstatus_i = 0;
    step(); step();
    check("rst_busy", 44'(busy_o), 44'(0));
    check("rst_we", 44'(csr_we_clint), 44'(0));
    check("rst_hold", 44'(hold_o), 44'(0));
    check("rst_jump", 44'(jump_o), 44'(0));
    check("rst_jaddr", 44'(jump_addr_o), 44'(0));
    rst_n = 1;
    step();

    // Directed scenarios.
    do_txn(1, 0, 0, 0, 0, 31'd2, 32'h100, 32'hDEAD, 0, 32'h200, 0, 32'h8, 0, 16'h0, 0);
    do_txn(0, 0, 1, 0, 1, 0, 0, 0, 32'h44, 32'h301, 0, 32'h8, 0, 16'h0, 0);
    do_txn(0, 0, 1, 0, 0, 0, 0, 0, 32'h44, 32'h301, 0, 32'h0, 0, 16'h0, 0);
    do_txn(0, 0, 1, 0, 1, 0, 0, 0, 32'h48, 32'h301, 0, 32'h8, 0, 16'h0, 0);
    do_txn(1, 1, 0, 0, 1, 31'd5, 32'h200, 32'h77, 32'h60, 32'h301, 0, 32'h8, 0, 16'h0, 1);
    do_txn(0, 1, 0, 0, 1, 0, 0, 0, 32'h60, 32'h301, 0, 32'h8, 0, 16'h0, 0);
    do_txn(0, 0, 0, 1, 0, 0, 0, 0, 0, 32'h200, 32'h104, 32'h1880, 0, 16'h0, 0);
    do_txn(1, 0, 0, 0, 0, 31'd4, 32'h300, 32'h1, 0, 32'h200, 0, 32'h0, 0, 16'b0110, 0);

    // Reset in the middle of a trap, once W_MTVAL is reached.
    exc_valid_i = 1; exc_cause_i = 31'd3; exc_pc_i = 32'h500; csr_mtvec_i = 32'h400;
    step();
    exc_valid_i = 0;
    step(); step();
    rst_n = 0;
    #1;
    check("mid_rst_we", 44'(csr_we_clint), 44'(0));
    check("mid_rst_busy", 44'(busy_o), 44'(0));
    check("mid_rst_hold", 44'(hold_o), 44'(0));
    check("mid_rst_jaddr", 44'(jump_addr_o), 44'(0));
    step();
    rst_n = 1;
    for (int k = 0; k < 3; k++) begin
      step();
      check("after_rst_we", 44'(csr_we_clint), 44'(0));
      check("after_rst_busy", 44'(busy_o), 44'(0));
    end

    // Random traffic with random port collisions.
    for (int n = 0; n < 40; n++) begin
      do_txn(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 31'($urandom),
             $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, 20, 16'h0, 0);
      if ($urandom_range(0, 2) == 0) step();
    end

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
